// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets, STATUS bit positions and FSM state encodings.
package mmio_uart_tx_pkg;

    localparam logic [11:0] OFF_TXDATA = 12'h800;
    localparam logic [11:0] OFF_STATUS = 12'h804;
    localparam logic [11:0] OFF_DIV    = 12'h808;
    localparam logic [11:0] OFF_OVFCLR = 12'h80C;
    localparam logic [11:0] OFF_HALT   = 12'hFFC;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // A zero divisor would stall the bit counter, so it behaves as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter.
// The head entry is readable combinationally so the transmitter can latch it on the pop edge.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    // Fullness is judged on the pre-pop count, so a push into a full FIFO is lost even when a pop happens.
    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, programmable baud divisor and halt flag.
// Decodes the 0x800-0xFFF window; reads return registered data one cycle later.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    output logic [31:0] data_out,
    output logic        sel,
    output logic        txd,
    output logic        halt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    tx_state_t   state_reg, state_next;
    logic [15:0] div_reg;
    logic [15:0] period_reg;
    logic [15:0] cnt_reg;
    logic [2:0]  bit_idx_reg;
    logic [7:0]  byte_reg;
    logic        overflow_reg;
    logic        busy;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rdata;
    logic [AW:0] fifo_count;
    logic [4:0]  count5;
    logic [11:0] offset;
    logic        wr_en;
    logic        push_req;
    logic [15:0] div_load;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign sel         = (address[31:12] == 20'd0) && address[11];
    assign offset      = {address[11:2], 2'b00};
    assign wr_en       = sel && we;
    assign push_req    = wr_en && (offset == OFF_TXDATA);
    assign div_load    = eff_div(div_reg);
    assign count5      = 5'(fifo_count);
    assign unused_bits = ^{data_in[31:16], address[1:0]};

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_req),
        .wdata  (data_in[7:0]),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (!fifo_empty) state_next = S_START;
            S_START: if (cnt_reg == 16'd0) state_next = S_DATA;
            S_DATA:  if (cnt_reg == 16'd0 && bit_idx_reg == 3'd7) state_next = S_STOP;
            S_STOP:  if (cnt_reg == 16'd0) state_next = fifo_empty ? S_IDLE : S_START;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        txd      = 1'b1;
        busy     = (state_reg != S_IDLE);
        fifo_pop = !fifo_empty &&
                   ((state_reg == S_IDLE) || (state_reg == S_STOP && cnt_reg == 16'd0));
        case (state_reg)
            S_START: txd = 1'b0;
            S_DATA:  txd = byte_reg[bit_idx_reg];
            default: txd = 1'b1;
        endcase
    end

    // The divisor is sampled only when a byte is popped, so DIV writes take effect from the next frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_reg    <= 8'd0;
            period_reg  <= 16'd0;
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
        end else if (fifo_pop) begin
            byte_reg    <= fifo_rdata;
            period_reg  <= div_load;
            cnt_reg     <= div_load - 16'd1;
            bit_idx_reg <= 3'd0;
        end else if (state_reg != S_IDLE) begin
            if (cnt_reg == 16'd0) begin
                cnt_reg <= (state_next == S_IDLE) ? 16'd0 : period_reg - 16'd1;
                if (state_reg == S_DATA) bit_idx_reg <= bit_idx_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg - 16'd1;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (offset)
            OFF_STATUS: begin
                rd_mux[ST_FULL]            = fifo_full;
                rd_mux[ST_EMPTY]           = fifo_empty;
                rd_mux[ST_BUSY]            = busy;
                rd_mux[ST_OVF]             = overflow_reg;
                rd_mux[ST_CNT_LSB +: 5]    = count5;
            end
            OFF_DIV: rd_mux = {16'd0, div_reg};
            default: rd_mux = 32'd0;
        endcase
    end

    // A dropped push in the same cycle as an OVFCLR write keeps the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_reg      <= 16'(DIV_RESET);
            overflow_reg <= 1'b0;
            halt         <= 1'b0;
            data_out     <= 32'd0;
        end else begin
            if (wr_en && offset == OFF_DIV)  div_reg <= data_in[15:0];
            if (wr_en && offset == OFF_HALT) halt    <= 1'b1;
            if (push_req && fifo_full)
                overflow_reg <= 1'b1;
            else if (wr_en && offset == OFF_OVFCLR)
                overflow_reg <= 1'b0;
            data_out <= (sel && !we) ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: predicts the serial waveform from the 8N1 framing rules
// and checks register reads, overflow, halt and reset behaviour.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic        we = 1'b0;
    logic [31:0] data_out;
    logic        sel;
    logic        txd;
    logic        halt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] op_addr[$];
    logic [31:0] op_data[$];
    bit          exp_txd[$];
    bit          exp_frm[$];

    mmio_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .address  (address),
        .data_in  (data_in),
        .we       (we),
        .data_out (data_out),
        .sel      (sel),
        .txd      (txd),
        .halt     (halt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; data_in = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; address = 32'd0;
        $display("wr  addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        address = a; we = 1'b0;
        @(negedge clk);
        v = data_out;
        address = 32'd0;
        $display("rd  addr=0x%08h data=0x%08h", a, v);
    endtask

    task automatic add_idle(input int n);
        repeat (n) begin
            exp_txd.push_back(1'b1);
            exp_frm.push_back(1'b0);
        end
    endtask

    // Start bit, eight data bits LSB first, stop bit; each lasts p clocks.
    task automatic add_frame(input logic [7:0] b, input int p);
        for (int k = 0; k < 10; k++) begin
            bit v;
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (p) begin
                exp_txd.push_back(v);
                exp_frm.push_back(1'b1);
            end
        end
    endtask

    // Issues the queued writes on consecutive edges, then reads STATUS every cycle,
    // comparing txd each cycle and the busy bit against the previous cycle's framing.
    task automatic run_ops(input string name);
        int m;
        m = op_addr.size();
        for (int i = 0; i < exp_txd.size(); i++) begin
            @(negedge clk);
            check({name, "_txd"}, {31'd0, txd}, {31'd0, exp_txd[i]});
            if (i >= m + 1)
                check({name, "_busy"}, {31'd0, data_out[2]}, {31'd0, exp_frm[i-1]});
            if (i < m) begin
                address = op_addr[i]; data_in = op_data[i]; we = 1'b1;
            end else begin
                address = 32'h804; we = 1'b0;
            end
        end
        $display("stream %s: %0d ops, %0d cycles", name, m, exp_txd.size());
        op_addr.delete(); op_data.delete(); exp_txd.delete(); exp_frm.delete();
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] d);
        op_addr.push_back(a);
        op_data.push_back(d);
    endtask

    initial begin
        logic [31:0] v;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_dout", data_out, 32'd0);
        resetn = 1'b1;

        rd(32'h804, v);  check("status_reset", v, 32'h2);
        rd(32'h808, v);  check("div_reset", v, 32'd16);
        rd(32'h810, v);  check("unmapped_rd", v, 32'd0);

        // DIV=4, single 0x55 frame
        push_op(32'h808, 32'd4);
        push_op(32'h800, 32'hABCD_0055);
        add_idle(3); add_frame(8'h55, 4); add_idle(3);
        run_ops("div4_55");
        rd(32'h808, v);  check("div_rd4", v, 32'd4);

        for (int t = 0; t < 4; t++) begin
            int d, n, p;
            d = $urandom_range(0, 6);
            n = $urandom_range(1, 5);
            p = (d == 0) ? 1 : d;
            push_op(32'h808, d);
            add_idle(3);
            for (int j = 0; j < n; j++) begin
                logic [31:0] w;
                w = $urandom;
                push_op(32'h800 | (j % 4), w);
                add_frame(w[7:0], p);
            end
            add_idle(3);
            run_ops($sformatf("rand%0d", t));
            rd(32'h808, v);  check("div_rd_rand", v, d);
        end

        // DIV changed to 2 while a DIV=8 frame is on the line
        push_op(32'h808, 32'd8);
        push_op(32'h800, 32'h0000_00C3);
        push_op(32'h808, 32'd2);
        push_op(32'h800, 32'h0000_003C);
        add_idle(3); add_frame(8'hC3, 8); add_frame(8'h3C, 2); add_idle(3);
        run_ops("divchg");

        // halt and address decode
        check("halt_pre", {31'd0, halt}, 32'd0);
        wr(32'hFFC, 32'd1);
        check("halt_set", {31'd0, halt}, 32'd1);
        repeat (5) @(negedge clk);
        check("halt_hold", {31'd0, halt}, 32'd1);
        address = 32'h400;   #1 check("sel_400", {31'd0, sel}, 32'd0);
        address = 32'h1804;  #1 check("sel_1804", {31'd0, sel}, 32'd0);
        address = 32'hC00;   #1 check("sel_c00", {31'd0, sel}, 32'd1);
        wr(32'h400, 32'h41);
        repeat (3) begin
            @(negedge clk);
            check("idle_txd_400", {31'd0, txd}, 32'd1);
        end
        rd(32'h804, v);  check("status_400", v, 32'h2);

        // overflow: ten back-to-back pushes at DIV=16
        wr(32'h808, 32'd16);
        for (int j = 0; j < 10; j++) wr(32'h800, j + 1);
        rd(32'h804, v);  check("status_ovf", v, 32'h8D);
        wr(32'h80C, 32'd0);
        rd(32'h804, v);  check("status_ovfclr", v, 32'h85);
        check("halt_persist", {31'd0, halt}, 32'd1);

        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_txd", {31'd0, txd}, 32'd1);
        check("arst_halt", {31'd0, halt}, 32'd0);
        check("arst_dout", data_out, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        rd(32'h804, v);  check("status_after_rst", v, 32'h2);

        // reset during data bit 3 of 0xA6 (bit value 0)
        push_op(32'h808, 32'd4);
        push_op(32'h800, 32'h0000_00A6);
        push_op(32'h800, 32'h0000_0011);
        add_idle(3); add_frame(8'hA6, 4);
        while (exp_txd.size() > 21) begin
            void'(exp_txd.pop_back());
            void'(exp_frm.pop_back());
        end
        run_ops("midframe");
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_dout", data_out, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_txd", {31'd0, txd}, 32'd1);
        end
        rd(32'h804, v);  check("status_mid_rst", v, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX FIFO entries (power of two).
REQ-002 Parameter DIV_RESET, default 16, reset value of the baud divisor in clocks per bit.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 resetn  input  1  reset is asynchronous and active-low.
REQ-005 address  input  32  byte address from core, shared with memory.
REQ-006 data_in  input  32  core write data (core data_out).
REQ-007 we  input  1  core write enable.
REQ-008 data_out  output  32  registered read data toward core read mux.
REQ-009 sel  output  1  combinational: address[31:12]==0 and address[11]==1.
REQ-010 txd  output  1  serial line, 8N1, idle high.
REQ-011 halt  output  1  sticky stop request to testbench/top.

Function
REQ-012 Register map, word aligned, address[1:0] ignored: 0x800 TXDATA (W), 0x804 STATUS (R), 0x808 DIV (R/W, 16 bits), 0x80C OVFCLR (W), 0xFFC HALT (W); other sel addresses read 0, writes ignored.
REQ-013 Write = sel and we at posedge; no effect when sel=0.
REQ-014 TXDATA write pushes data_in[7:0]; if FIFO full (pre-pop count == FIFO_DEPTH) byte is dropped and overflow sets, even if a pop occurs that cycle.
REQ-015 STATUS = {23'b0, count[4:0], overflow, busy, empty, full} in bits [31:0] = {.., [8:4] count, [3] overflow, [2] busy, [1] empty, [0] full}.
REQ-016 Read: at posedge with sel=1, we=0, data_out <= selected register; otherwise data_out <= 0; one-cycle latency.
REQ-017 OVFCLR write clears overflow; a same-cycle overflow event wins (overflow stays 1).
REQ-018 HALT write sets halt at the next posedge; halt holds until reset.
REQ-019 FSM states IDLE, START, DATA, STOP; busy = state != IDLE.
REQ-020 IDLE: txd=1; if FIFO non-empty, pop head, latch DIV (0 treated as 1) into bit period, go START.
REQ-021 START: txd=0 for one bit period, then DATA with bit index 0.
REQ-022 DATA: txd = byte[index], LSB first, one bit period each; after index 7 go STOP.
REQ-023 STOP: txd=1 one bit period; then START directly with a new pop if FIFO non-empty, else IDLE.
REQ-024 Frame = 10 bit periods exactly; byte written at edge k into empty FIFO with FSM IDLE drives start bit from edge k+1.
REQ-025 DIV writes mid-frame affect only the next frame.
REQ-026 Bit-period counter 16 bits, counts down, no wrap beyond divisor.

Reset
REQ-027 resetn low asynchronously forces: txd=1, halt=0, data_out=0, state IDLE, FIFO empty, overflow=0, DIV=DIV_RESET, counters 0.
REQ-028 Reset mid-frame aborts the frame; txd high immediately, queued bytes discarded.

Structure
REQ-029 Shared package/include holds register offsets, STATUS bit indices, FSM state encodings.
REQ-030 One sub-module, sync_fifo (8-bit wide, FIFO_DEPTH deep, push/pop/full/empty/count).

Verification
REQ-031 Reset then read 0x804 -> data_out=0x00000002 next cycle; txd=1, halt=0.
REQ-032 DIV<-4, TXDATA<-0x55 -> txd 0,1,0,1,0,1,0,1,0,1 each 4 cycles, 40 cycles total, busy 1 throughout, then IDLE.
REQ-033 DIV=16, ten back-to-back TXDATA writes -> bytes 1-9 accepted, 10th dropped, STATUS=0x89|... reads full=1, overflow=1, count=8; OVFCLR write -> overflow=0.
REQ-034 DIV<-2 during a DIV=8 frame -> current frame 80 cycles, next frame 20 cycles, no idle gap between them.
REQ-035 Write 0xFFC -> halt=1 next cycle, persists; write to 0x400 -> sel=0, no FIFO change.
REQ-036 resetn low during DATA bit 3 -> txd=1 same time step, STATUS after release = 0x00000002.
